systolic_drain_deskew: RTL and testbench

- Consumer on the output side of the systolic PE array. Captures the column-skewed results on the array's o_down_data bus and realigns each result row across all columns.
- Buffers the aligned rows in a FIFO and presents them as a valid/ready row stream to the result writeback path.
- The array cannot stall, so a drain is admitted only when the FIFO can absorb the whole tile.

---
 rtl/systolic_drain_deskew.sv | 179 +++++++++++++++++
 tb/tb_systolic_drain_deskew.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_drain_deskew.sv
// Deskews column-staggered PE array results into aligned rows and buffers them in a
// show-ahead row FIFO. Define SYSTOLIC_DRAIN_RELU_EN to clamp negative elements to 0 at FIFO write.
module systolic_drain_deskew #(
   parameter int PE_ARRAY_W     = 64,
   parameter int PE_ARRAY_H     = 64,
   parameter int OUT_DATA_WIDTH = 24,
   parameter int DRAIN_LAT      = 64,
   parameter int FIFO_DEPTH     = 64
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             i_start,
   input  logic [$clog2(PE_ARRAY_H):0]      i_rows,
   output logic                             o_start_rdy,
   output logic                             o_err,
   input  logic signed [OUT_DATA_WIDTH-1:0] i_down_data [0:PE_ARRAY_W-1],
   output logic                             o_vld,
   input  logic                             i_rdy,
   output logic signed [OUT_DATA_WIDTH-1:0] o_row_data [0:PE_ARRAY_W-1],
   output logic                             o_done,
   output logic                             o_busy
);

   localparam int RW  = $clog2(PE_ARRAY_H) + 1;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int PW  = AW + 1;
   localparam int WCW = $clog2(DRAIN_LAT + PE_ARRAY_W) + 1;

   localparam logic [RW-1:0]  ROWS_MAX  = RW'(PE_ARRAY_H);
   localparam logic [PW-1:0]  DEPTH_P   = PW'(FIFO_DEPTH);
   localparam logic [PW-1:0]  TILE_P    = PW'(PE_ARRAY_H);
   localparam logic [WCW-1:0] WAIT_LOAD = WCW'(DRAIN_LAT + PE_ARRAY_W - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE} state_t;

   function automatic logic signed [OUT_DATA_WIDTH-1:0] relu_clamp(
      input logic signed [OUT_DATA_WIDTH-1:0] x);
`ifdef SYSTOLIC_DRAIN_RELU_EN
      return x[OUT_DATA_WIDTH-1] ? '0 : x;
`else
      return x;
`endif
   endfunction

   state_t               state_q, state_d;
   logic [WCW-1:0]       wait_q;
   logic [RW-1:0]        rows_q;
   logic [RW-1:0]        row_q;
   logic                 done_p1, err_p1;
   logic [PW-1:0]        wr_ptr, rd_ptr;
   logic [PW-1:0]        fill, free_cnt;
   logic                 empty, full;
   logic                 start_rdy, rows_ok;
   logic                 accept, bad_start, push, last_push, pop;

   logic signed [OUT_DATA_WIDTH-1:0] aligned_row [PE_ARRAY_W];
   logic signed [OUT_DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH][PE_ARRAY_W];

   // Stage p0: column c is delayed by W-1-c cycles so every column lines up with the last one
   for (genvar c = 0; c < PE_ARRAY_W; c++) begin : g_col
      localparam int LEN = PE_ARRAY_W - 1 - c;
      if (LEN == 0) begin : g_direct
         assign aligned_row[c] = i_down_data[c];
      end else begin : g_line
         logic signed [OUT_DATA_WIDTH-1:0] dsk_p0 [LEN];
         always_ff @(posedge clk) begin
            if (!rst) begin
               for (int k = 0; k < LEN; k++) dsk_p0[k] <= '0;
            end else begin
               dsk_p0[0] <= i_down_data[c];
               for (int k = 1; k < LEN; k++) dsk_p0[k] <= dsk_p0[k-1];
            end
         end
         assign aligned_row[c] = dsk_p0[LEN-1];
      end
   end

   assign fill      = wr_ptr - rd_ptr;
   assign free_cnt  = DEPTH_P - fill;
   assign empty     = (fill == '0);
   assign full      = (fill == DEPTH_P);
   assign start_rdy = (state_q == S_IDLE) && (free_cnt >= TILE_P) && rst;
   assign rows_ok   = (i_rows != '0) && (i_rows <= ROWS_MAX);
   assign pop       = o_vld && i_rdy;

   always_ff @(posedge clk) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // The final WAIT cycle (counter expiring) already carries aligned row 0
   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      bad_start = 1'b0;
      push      = 1'b0;
      last_push = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_start && start_rdy) begin
               if (rows_ok) begin
                  accept  = 1'b1;
                  state_d = S_WAIT;
               end else begin
                  bad_start = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (wait_q == WCW'(1)) begin
               push = 1'b1;
               if (rows_q == RW'(1)) begin
                  last_push = 1'b1;
                  state_d   = S_IDLE;
               end else begin
                  state_d = S_CAPTURE;
               end
            end
         end
         S_CAPTURE: begin
            push = 1'b1;
            if (row_q == rows_q - RW'(1)) begin
               last_push = 1'b1;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wait_q  <= '0;
         rows_q  <= '0;
         row_q   <= '0;
         done_p1 <= 1'b0;
         err_p1  <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
      end else begin
         done_p1 <= last_push;
         err_p1  <= bad_start;
         if (accept) begin
            rows_q <= i_rows;
            wait_q <= WAIT_LOAD;
            row_q  <= '0;
         end else if (state_q == S_WAIT) begin
            wait_q <= wait_q - WCW'(1);
         end
         if (push) begin
            row_q  <= row_q + RW'(1);
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Stage p1: FIFO write of the aligned (optionally clamped) row
   always_ff @(posedge clk) begin
      if (rst && push) begin
         for (int c = 0; c < PE_ARRAY_W; c++)
            fifo_mem[wr_ptr[AW-1:0]][c] <= relu_clamp(aligned_row[c]);
      end
   end

   always_comb begin
      for (int c = 0; c < PE_ARRAY_W; c++)
         o_row_data[c] = o_vld ? fifo_mem[rd_ptr[AW-1:0]][c] : '0;
   end

   assign o_vld       = rst && !empty;
   assign o_start_rdy = start_rdy;
   assign o_done      = rst && done_p1;
   assign o_err       = rst && err_p1;
   assign o_busy      = rst && (state_q != S_IDLE);

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && full));

endmodule

// File: tb/tb_systolic_drain_deskew.sv
// Randomized bench for systolic_drain_deskew (W=4, H=4, DRAIN_LAT=3, FIFO_DEPTH=8) against a
// queue-based row model; honours SYSTOLIC_DRAIN_RELU_EN in its expectations.
module tb_systolic_drain_deskew;
   localparam int W    = 4;
   localparam int H    = 4;
   localparam int L    = 3;
   localparam int D    = 8;
   localparam int DW   = 24;
   localparam int RW   = 3;
   localparam int RWID = W * DW;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic i_start = 1'b0;
   logic [RW-1:0] i_rows = '0;
   logic i_rdy = 1'b0;
   logic o_start_rdy, o_err, o_vld, o_done, o_busy;
   logic signed [DW-1:0] down_data [0:W-1];
   logic signed [DW-1:0] row_data [0:W-1];

   systolic_drain_deskew #(
      .PE_ARRAY_W(W), .PE_ARRAY_H(H), .OUT_DATA_WIDTH(DW), .DRAIN_LAT(L), .FIFO_DEPTH(D)
   ) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_rows(i_rows),
      .o_start_rdy(o_start_rdy), .o_err(o_err), .i_down_data(down_data),
      .o_vld(o_vld), .i_rdy(i_rdy), .o_row_data(row_data),
      .o_done(o_done), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int               avail;
      logic [RWID-1:0]  data;
   } row_t;

   row_t exp_q[$];
   int   cyc = 0;
   int   busy_until = 0;
   int   done_edge = -1;
   int   err_edge = -1;
   int   tile_t = 0;
   int   tile_rows = 0;
   bit   tile_act = 1'b0;
   int   rdy_mode = 1;
   int   checks = 0;
   int   failures = 0;
   logic [DW-1:0] tdat [H][W];

   task automatic chk(input string tag, input logic [RWID-1:0] got, input logic [RWID-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] relu_ref(input logic [DW-1:0] v);
`ifdef SYSTOLIC_DRAIN_RELU_EN
      return ($signed(v) < 0) ? '0 : v;
`else
      return v;
`endif
   endfunction

   function automatic int pushed_cnt();
      int n = 0;
      foreach (exp_q[i]) if (exp_q[i].avail <= cyc) n++;
      return n;
   endfunction

   function automatic bit model_rdy();
      return rst && (cyc >= busy_until) && ((D - pushed_cnt()) >= H);
   endfunction

   function automatic bit model_vld();
      return rst && (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
   endfunction

   function automatic logic [RWID-1:0] pack_out();
      logic [RWID-1:0] v;
      for (int c = 0; c < W; c++) v[c*DW +: DW] = row_data[c];
      return v;
   endfunction

   // Model update at the clock edge: reset flush or a pop of the visible head
   always @(posedge clk) begin
      if (!rst) begin
         exp_q.delete();
         busy_until = 0;
         done_edge  = -1;
         err_edge   = -1;
         tile_act   = 1'b0;
      end else if (model_vld() && i_rdy) begin
         void'(exp_q.pop_front());
      end
      cyc++;
   end

   // Check outputs away from the edge, then drive ready and skewed column data for the next edge
   always @(negedge clk) begin
      if (!rst) begin
         chk("rst_vld", RWID'(o_vld), '0);
         chk("rst_rdy", RWID'(o_start_rdy), '0);
         chk("rst_busy", RWID'(o_busy), '0);
         chk("rst_done", RWID'(o_done), '0);
         chk("rst_err", RWID'(o_err), '0);
         chk("rst_data", pack_out(), '0);
      end else begin
         chk("start_rdy", RWID'(o_start_rdy), RWID'(model_rdy()));
         chk("busy", RWID'(o_busy), RWID'(cyc < busy_until));
         chk("done", RWID'(o_done), RWID'(cyc == done_edge));
         chk("err", RWID'(o_err), RWID'(cyc == err_edge));
         chk("vld", RWID'(o_vld), RWID'(model_vld()));
         if (model_vld()) chk("row", pack_out(), exp_q[0].data);
      end
      case (rdy_mode)
         0:       i_rdy = 1'b0;
         1:       i_rdy = 1'b1;
         default: i_rdy = 1'($urandom_range(0, 1));
      endcase
      for (int c = 0; c < W; c++) begin
         int r;
         r = cyc + 1 - tile_t - L - c;
         if (tile_act && r >= 0 && r < tile_rows) down_data[c] = tdat[r][c];
         else                                     down_data[c] = DW'($urandom);
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_rdy();
      int n = 0;
      while (!model_rdy() && n < 300) begin
         step();
         n++;
      end
      chk("rdy_wait", RWID'(n < 300), RWID'(1));
   endtask

   // pat: 0 = 16*r+c, 1 = random, 2 = alternating -16 / +16
   task automatic do_start(input int rows, input int pat);
      wait_rdy();
      i_start = 1'b1;
      i_rows  = RW'(rows);
      if (rows >= 1 && rows <= H) begin
         for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
               case (pat)
                  0:       tdat[r][c] = DW'(16 * r + c);
                  1:       tdat[r][c] = DW'($urandom);
                  default: tdat[r][c] = (c % 2 == 1) ? 24'h000010 : 24'hFFFFF0;
               endcase
         tile_t    = cyc + 1;
         tile_rows = rows;
         tile_act  = 1'b1;
         for (int r = 0; r < rows; r++) begin
            row_t e;
            e.avail = tile_t + L + W - 1 + r;
            for (int c = 0; c < W; c++) e.data[c*DW +: DW] = relu_ref(tdat[r][c]);
            exp_q.push_back(e);
         end
         busy_until = tile_t + L + W - 1 + rows - 1;
         done_edge  = busy_until;
      end else begin
         err_edge = cyc + 1;
      end
      step();
      i_start = 1'b0;
   endtask

   initial begin
      step();
      step();
      step();
      rst = 1'b1;
      step();

      rdy_mode = 1;
      do_start(4, 0);
      wait_rdy();

      do_start(0, 0);
      step();
      do_start(5, 0);
      step();

      rdy_mode = 0;
      do_start(4, 1);
      do_start(4, 1);
      while (cyc < busy_until + 2) step();
      i_start = 1'b1;
      i_rows  = RW'(2);
      step();
      i_start = 1'b0;
      repeat (3) step();
      rdy_mode = 1;

      do_start(2, 1);
      do_start(2, 2);

      do_start(4, 1);
      while (cyc < tile_t + L + W) step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      do_start(4, 0);

      rdy_mode = 2;
      repeat (12) begin
         if ($urandom_range(0, 5) == 0) do_start(($urandom_range(0, 1) == 1) ? 0 : 6, 0);
         else                           do_start(int'($urandom_range(1, H)), 1);
      end

      rdy_mode = 1;
      begin
         int n = 0;
         while ((exp_q.size() > 0 || cyc < busy_until) && n < 300) begin
            step();
            n++;
         end
      end
      chk("drain", RWID'(exp_q.size()), '0);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
